// File: rtl/npc_ras_if.sv
// Control-side bundle for the next-PC unit: select/operand inputs from decode
// and ALU, PC and return-stack status back out to fetch.
interface npc_ras_if #(
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic          stall;
  logic [2:0]    nPCOp;
  logic          zero;
  logic [15:0]   imm16;
  logic [25:0]   imm26;
  logic [31:0]   reg_target;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [CW-1:0] ras_count;
  logic          ras_underflow;

  modport master (
    output stall, nPCOp, zero, imm16, imm26, reg_target,
    input  pc, pc_plus4, ras_count, ras_underflow
  );

  modport slave (
    input  stall, nPCOp, zero, imm16, imm26, reg_target,
    output pc, pc_plus4, ras_count, ras_underflow
  );
endinterface

// File: rtl/npc_ras.sv
// Next-PC unit: owns the architectural PC and a circular return-address stack
// that JAL pushes and RET pops, with fetch stall and synchronous reset.
module npc_ras #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int          RAS_DEPTH   = 4,
  parameter bit          BR_BASE_PC4 = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  npc_ras_if.slave   bus
);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH) + 1;
  localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OP_NML = 3'b000,
    OP_BEQ = 3'b001,
    OP_J   = 3'b010,
    OP_BNE = 3'b011,
    OP_JAL = 3'b100,
    OP_JR  = 3'b101,
    OP_RET = 3'b110,
    OP_RSV = 3'b111
  } op_e;

  logic [31:0]   pc_q;
  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] ptr_q;
  logic [CW-1:0] cnt_q;
  logic          unf_q;

  op_e           op;
  logic [31:0]   pc_plus4;
  logic [31:0]   br_off;
  logic [31:0]   br_tgt;
  logic [31:0]   j_tgt;
  logic [31:0]   jr_tgt;
  logic [31:0]   pc_next;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;
  logic          ras_empty;
  logic          push;
  logic          pop;
  logic          unf_next;
  logic          adv;

  assign op        = op_e'(bus.nPCOp);
  assign pc_plus4  = pc_q + 32'd4;
  assign br_off    = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign br_tgt    = (BR_BASE_PC4 ? pc_plus4 : pc_q) + br_off;
  assign j_tgt     = {pc_q[31:28], bus.imm26, 2'b00};
  assign jr_tgt    = {bus.reg_target[31:2], 2'b00};
  assign ptr_inc   = ptr_q + PW'(1);
  assign ptr_dec   = ptr_q - PW'(1);
  assign ras_empty = (cnt_q == '0);
  assign adv       = !rst && !bus.stall;

  // Exactly one of push/pop can be asserted; RET on an empty stack falls
  // back to the register target and flags the underflow instead of popping.
  always_comb begin
    pc_next  = pc_plus4;
    push     = 1'b0;
    pop      = 1'b0;
    unf_next = 1'b0;
    case (op)
      OP_BEQ: if (bus.zero)  pc_next = br_tgt;
      OP_BNE: if (!bus.zero) pc_next = br_tgt;
      OP_J:   pc_next = j_tgt;
      OP_JAL: begin
        pc_next = j_tgt;
        push    = 1'b1;
      end
      OP_JR:  pc_next = jr_tgt;
      OP_RET: begin
        if (!ras_empty) begin
          pc_next = ras_mem[ptr_q];
          pop     = 1'b1;
        end else begin
          pc_next  = jr_tgt;
          unf_next = 1'b1;
        end
      end
      default: pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= {RESET_PC[31:2], 2'b00};
      ptr_q <= '0;
      cnt_q <= '0;
      unf_q <= 1'b0;
    end else if (bus.stall) begin
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_next;
      unf_q <= unf_next;
      if (push) begin
        // A push on a full stack wraps onto the oldest slot; count saturates.
        ptr_q <= ptr_inc;
        if (cnt_q != RAS_FULL) cnt_q <= cnt_q + CW'(1);
      end else if (pop) begin
        ptr_q <= ptr_dec;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // Entry storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (adv && push) ras_mem[ptr_inc] <= pc_plus4;
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_plus4;
  assign bus.ras_count     = cnt_q;
  assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_npc_ras.sv
// Bench for npc_ras: two instances (pc+4 and pc branch base) driven in lockstep
// and compared against a queue-based return-stack model plus directed values.
module tb_npc_ras;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [2:0] NML = 3'd0, BEQ = 3'd1, J = 3'd2, BNE = 3'd3,
                         JAL = 3'd4, JR  = 3'd5, RET = 3'd6;

  logic        clk = 1'b0;
  logic        rst, stall, zero;
  logic [2:0]  op;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  npc_ras_if #(.RAS_DEPTH(DEPTH)) bus_a ();
  npc_ras_if #(.RAS_DEPTH(DEPTH)) bus_b ();

  assign bus_a.stall = stall;  assign bus_b.stall = stall;
  assign bus_a.nPCOp = op;     assign bus_b.nPCOp = op;
  assign bus_a.zero  = zero;   assign bus_b.zero  = zero;
  assign bus_a.imm16 = imm16;  assign bus_b.imm16 = imm16;
  assign bus_a.imm26 = imm26;  assign bus_b.imm26 = imm26;
  assign bus_a.reg_target = rt;
  assign bus_b.reg_target = rt;

  npc_ras #(.RESET_PC(32'h0000_3000), .RAS_DEPTH(DEPTH), .BR_BASE_PC4(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  npc_ras #(.RESET_PC(32'h0000_3000), .RAS_DEPTH(DEPTH), .BR_BASE_PC4(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  // Reference: PC as a number, stack as a queue (back = top, front = oldest).
  logic [31:0] m_pc_a, m_pc_b;
  logic        m_unf_a, m_unf_b;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  function automatic logic [31:0] model_next(input logic [31:0] p, input bit base4,
                                             input bit have_top, input logic [31:0] top);
    int off;
    off = int'($signed(imm16)) * 4;
    case (op)
      BEQ:     return zero  ? (base4 ? p + 4 : p) + 32'(off) : p + 4;
      BNE:     return !zero ? (base4 ? p + 4 : p) + 32'(off) : p + 4;
      J, JAL:  return (p & 32'hF000_0000) | (32'(imm26) * 4);
      JR:      return rt & ~32'd3;
      RET:     return have_top ? top : (rt & ~32'd3);
      default: return p + 4;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] na, nb;
    if (rst) begin
      m_pc_a = 32'h3000; m_pc_b = 32'h3000;
      q_a.delete(); q_b.delete();
      m_unf_a = 1'b0; m_unf_b = 1'b0;
    end else if (stall) begin
      m_unf_a = 1'b0; m_unf_b = 1'b0;
    end else begin
      na = model_next(m_pc_a, 1'b1, q_a.size() > 0, (q_a.size() > 0) ? q_a[$] : 32'd0);
      nb = model_next(m_pc_b, 1'b0, q_b.size() > 0, (q_b.size() > 0) ? q_b[$] : 32'd0);
      m_unf_a = (op == RET) && (q_a.size() == 0);
      m_unf_b = (op == RET) && (q_b.size() == 0);
      if (op == JAL) begin
        q_a.push_back(m_pc_a + 4); if (q_a.size() > DEPTH) void'(q_a.pop_front());
        q_b.push_back(m_pc_b + 4); if (q_b.size() > DEPTH) void'(q_b.pop_front());
      end else if (op == RET) begin
        if (q_a.size() > 0) void'(q_a.pop_back());
        if (q_b.size() > 0) void'(q_b.pop_back());
      end
      m_pc_a = na; m_pc_b = nb;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [2:0] o, input logic z,
                      input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] t);
    rst = r; stall = s; op = o; zero = z; imm16 = i16; imm26 = i26; rt = t;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, NML, 0, 0, 0, 0);
    step(1, 1, JAL, 0, 0, 0, 0);
    n_chk++; if (bus_a.pc !== 32'h3000) begin n_fail++; $display("FAIL reset_pc: got %h want 00003000", bus_a.pc); end
    n_chk++; if (bus_b.pc !== 32'h3000) begin n_fail++; $display("FAIL reset_pc_b: got %h want 00003000", bus_b.pc); end
    n_chk++; if (bus_a.pc_plus4 !== 32'h3004) begin n_fail++; $display("FAIL reset_pc4: got %h want 00003004", bus_a.pc_plus4); end
    n_chk++; if (bus_a.ras_count !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus_a.ras_count); end
    n_chk++; if (bus_a.ras_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_unf: got %b want 0", bus_a.ras_underflow); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, NML, 0, 0, 0, 0);
      n_chk++; if (bus_a.pc !== 32'h3000 + 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus_a.pc, 32'h3000 + 32'(4 * i)); end
      n_chk++; if (bus_a.pc_plus4 !== 32'h3004 + 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc4[%0d]: got %h want %h", i, bus_a.pc_plus4, 32'h3004 + 32'(4 * i)); end
    end
  endtask

  task automatic test_branch();
    logic [2:0]  t_op [4] = '{BEQ, BEQ, BNE, BNE};
    logic        t_z  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] t_a  [4] = '{32'h300C, 32'h3014, 32'h300C, 32'h3014};
    logic [31:0] t_b  [4] = '{32'h3008, 32'h3014, 32'h3008, 32'h3014};
    for (int i = 0; i < 4; i++) begin
      step(0, 0, JR, 0, 0, 0, 32'h3010);
      step(0, 0, t_op[i], t_z[i], 16'hFFFE, 0, 0);
      n_chk++; if (bus_a.pc !== t_a[i]) begin n_fail++; $display("FAIL branch_pc4[%0d]: got %h want %h", i, bus_a.pc, t_a[i]); end
      n_chk++; if (bus_b.pc !== t_b[i]) begin n_fail++; $display("FAIL branch_pc[%0d]: got %h want %h", i, bus_b.pc, t_b[i]); end
    end
  endtask

  task automatic test_jump();
    step(1, 0, NML, 0, 0, 0, 0);
    step(0, 0, J, 0, 0, 26'h0000C40, 0);
    n_chk++; if (bus_a.pc !== 32'h3100) begin n_fail++; $display("FAIL j_pc: got %h want 00003100", bus_a.pc); end
    step(0, 0, JR, 0, 0, 0, 32'h0040_0007);
    n_chk++; if (bus_a.pc !== 32'h0040_0004) begin n_fail++; $display("FAIL jr_pc: got %h want 00400004", bus_a.pc); end
  endtask

  task automatic test_nested();
    logic [25:0] t_i26 [4] = '{26'hC40, 26'hC80, 26'h0, 26'h0};
    logic [2:0]  t_op  [4] = '{JAL, JAL, RET, RET};
    logic [31:0] t_pc  [4] = '{32'h3100, 32'h3200, 32'h3104, 32'h3004};
    int          t_cnt [4] = '{1, 2, 1, 0};
    step(1, 0, NML, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, t_op[i], 0, 0, t_i26[i], 32'h0000_7770);
      n_chk++; if (bus_a.pc !== t_pc[i]) begin n_fail++; $display("FAIL nest_pc[%0d]: got %h want %h", i, bus_a.pc, t_pc[i]); end
      n_chk++; if (bus_a.ras_count !== CW'(t_cnt[i])) begin n_fail++; $display("FAIL nest_cnt[%0d]: got %0d want %0d", i, bus_a.ras_count, t_cnt[i]); end
    end
    n_chk++; if (bus_a.ras_underflow !== 1'b0) begin n_fail++; $display("FAIL nest_unf: got %b want 0", bus_a.ras_underflow); end
  endtask

  task automatic test_overflow();
    step(1, 0, NML, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, JAL, 0, 0, 26'((32'h4000 + 32'(i * 'h100)) >> 2), 0);
    n_chk++; if (bus_a.ras_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_cnt: got %0d want %0d", bus_a.ras_count, DEPTH); end
    for (int j = 0; j < 4; j++) begin
      step(0, 0, RET, 0, 0, 0, 32'h0000_9990);
      n_chk++; if (bus_a.pc !== 32'h4304 - 32'(j * 'h100)) begin n_fail++; $display("FAIL ovf_ret[%0d]: got %h want %h", j, bus_a.pc, 32'h4304 - 32'(j * 'h100)); end
      n_chk++; if (bus_a.ras_underflow !== 1'b0) begin n_fail++; $display("FAIL ovf_unf[%0d]: got %b want 0", j, bus_a.ras_underflow); end
    end
    step(0, 0, RET, 0, 0, 0, 32'h3ABC);
    n_chk++; if (bus_a.pc !== 32'h3ABC) begin n_fail++; $display("FAIL unf_pc: got %h want 00003abc", bus_a.pc); end
    n_chk++; if (bus_a.ras_underflow !== 1'b1) begin n_fail++; $display("FAIL unf_pulse: got %b want 1", bus_a.ras_underflow); end
    n_chk++; if (bus_a.ras_count !== '0) begin n_fail++; $display("FAIL unf_cnt: got %0d want 0", bus_a.ras_count); end
    step(0, 0, NML, 0, 0, 0, 0);
    n_chk++; if (bus_a.ras_underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b want 0", bus_a.ras_underflow); end
    n_chk++; if (bus_a.pc !== 32'h3AC0) begin n_fail++; $display("FAIL unf_next_pc: got %h want 00003ac0", bus_a.pc); end
  endtask

  task automatic test_stall();
    step(1, 0, NML, 0, 0, 0, 0);
    step(0, 0, NML, 0, 0, 0, 0);
    step(0, 1, JAL, 0, 0, 26'hC40, 0);
    n_chk++; if (bus_a.pc !== 32'h3004) begin n_fail++; $display("FAIL stall_pc: got %h want 00003004", bus_a.pc); end
    n_chk++; if (bus_a.ras_count !== '0) begin n_fail++; $display("FAIL stall_cnt: got %0d want 0", bus_a.ras_count); end
    step(0, 0, JAL, 0, 0, 26'hC40, 0);
    n_chk++; if (bus_a.ras_count !== CW'(1)) begin n_fail++; $display("FAIL stall_push: got %0d want 1", bus_a.ras_count); end
    step(1, 1, JAL, 0, 0, 26'hC80, 0);
    n_chk++; if (bus_a.pc !== 32'h3000) begin n_fail++; $display("FAIL rst_stall_pc: got %h want 00003000", bus_a.pc); end
    n_chk++; if (bus_a.ras_count !== '0) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d want 0", bus_a.ras_count); end
    step(0, 0, RET, 0, 0, 0, 32'h5000);
    n_chk++; if (bus_a.pc !== 32'h5000) begin n_fail++; $display("FAIL rst_discard_pc: got %h want 00005000", bus_a.pc); end
    step(0, 1, NML, 0, 0, 0, 0);
    n_chk++; if (bus_a.ras_underflow !== 1'b0) begin n_fail++; $display("FAIL stall_unf_clear: got %b want 0", bus_a.ras_underflow); end
    n_chk++; if (bus_a.pc !== 32'h5000) begin n_fail++; $display("FAIL stall_hold: got %h want 00005000", bus_a.pc); end
  endtask

  task automatic test_wrap();
    step(0, 0, JR, 0, 0, 0, 32'hFFFF_FFFC);
    n_chk++; if (bus_a.pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h want 00000000", bus_a.pc_plus4); end
    step(0, 0, NML, 0, 0, 0, 0);
    n_chk++; if (bus_a.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 00000000", bus_a.pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
           1'($urandom), 16'($urandom), 26'($urandom), $urandom);
      n_chk++; if (bus_a.pc !== m_pc_a) begin n_fail++; $display("FAIL rnd_pc_a[%0d]: got %h want %h", i, bus_a.pc, m_pc_a); end
      n_chk++; if (bus_b.pc !== m_pc_b) begin n_fail++; $display("FAIL rnd_pc_b[%0d]: got %h want %h", i, bus_b.pc, m_pc_b); end
      n_chk++; if (bus_a.pc_plus4 !== m_pc_a + 4) begin n_fail++; $display("FAIL rnd_pc4[%0d]: got %h want %h", i, bus_a.pc_plus4, m_pc_a + 4); end
      n_chk++; if (bus_a.ras_count !== CW'(q_a.size())) begin n_fail++; $display("FAIL rnd_cnt_a[%0d]: got %0d want %0d", i, bus_a.ras_count, q_a.size()); end
      n_chk++; if (bus_b.ras_count !== CW'(q_b.size())) begin n_fail++; $display("FAIL rnd_cnt_b[%0d]: got %0d want %0d", i, bus_b.ras_count, q_b.size()); end
      n_chk++; if (bus_a.ras_underflow !== m_unf_a) begin n_fail++; $display("FAIL rnd_unf_a[%0d]: got %b want %b", i, bus_a.ras_underflow, m_unf_a); end
      n_chk++; if (bus_b.ras_underflow !== m_unf_b) begin n_fail++; $display("FAIL rnd_unf_b[%0d]: got %b want %b", i, bus_b.ras_underflow, m_unf_b); end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; op = NML; zero = 1'b0; imm16 = '0; imm26 = '0; rt = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_nested();
    test_overflow();
    test_stall();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/npc_ras.md
Name: npc_ras

Overview:
- Parametrised next-PC unit with an integrated PC register and a return-address stack (RAS).
- Supersedes the purely combinational next-PC logic. It owns the architectural PC, selects the next PC each cycle from sequential, branch, jump, register-jump and return sources, and supports fetch stall.
- Sits between control/ALU (op, zero, immediates, rs value) and instruction memory address.

Parameters:
- RESET_PC, 32'h0000_3000, byte address loaded into pc on reset; bits [1:0] must be 0.
- RAS_DEPTH, 4, number of RAS entries; power of two, 2..16.
- BR_BASE_PC4, 1, branch base: 1 = pc+4 (MIPS standard), 0 = pc (legacy word-relative).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- stall, input, 1, 1 = hold pc and RAS this cycle.
- nPCOp, input, 3, next-PC select: 000 NML, 001 BEQ, 010 J, 011 BNE, 100 JAL, 101 JR, 110 RET, 111 reserved.
- zero, input, 1, ALU equality result for BEQ/BNE.
- imm16, input, 16, branch offset in words.
- imm26, input, 26, jump index.
- reg_target, input, 32, rs value for JR, and fallback target for RET.
- pc, output, 32, current PC as a byte address; registered.
- pc_plus4, output, 32, pc+4; combinational from pc.
- ras_count, output, $clog2(RAS_DEPTH)+1, valid RAS entries; registered.
- ras_underflow, output, 1, one-cycle registered pulse: a RET was taken with an empty RAS.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, ras_count=0, top pointer=0, ras_underflow=0.
  - RAS entry contents are don't-care.
  - rst overrides stall and nPCOp.
- Stall:
  - stall=1 with rst=0 leaves pc, RAS, pointer and count unchanged.
  - ras_underflow clears to 0.
- Otherwise, each edge: pc <= next, where next is computed from the current pc:
  - NML: pc+4.
  - BEQ: if zero=1, base + (sext(imm16)<<2); else pc+4. base = pc+4 if BR_BASE_PC4=1, else pc.
  - BNE: same as BEQ with the zero condition inverted.
  - J: {pc[31:28], imm26, 2'b00}.
  - JAL: same target as J; pushes pc+4 onto the RAS.
  - JR: {reg_target[31:2], 2'b00}.
  - RET:
    - If ras_count>0: next = top entry, then pop.
    - If empty: next = {reg_target[31:2], 2'b00} and ras_underflow <= 1 for exactly one cycle.
  - 111: treated as NML.
- Arithmetic: all additions are modulo 2^32 and wrap silently, e.g. pc 0xFFFF_FFFC + 4 = 0x0000_0000. pc[1:0] is always 00.
- RAS organisation:
  - Circular buffer with a top pointer.
  - Push writes entry[ptr+1] and advances ptr. Pop reads entry[ptr] and retreats ptr. Pointer arithmetic is modulo RAS_DEPTH.
- RAS full:
  - A push when ras_count==RAS_DEPTH overwrites the oldest entry.
  - ras_count stays saturated at RAS_DEPTH. No error flag.
- RAS empty: a pop leaves ptr and ras_count unchanged (underflow case above).
- ras_underflow is 0 on every cycle except the one following an empty-RAS RET.
- Exactly one push or one pop per cycle is possible; no simultaneous push and pop exists.
- Reset mid-sequence discards all RAS contents.

Test Plan:
- Reset, then NML for 3 cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C; pc_plus4 = pc+4 in each cycle.
- Branches at pc=0x3010 with imm16=0xFFFE:
  - BEQ, zero=1 -> pc=0x300C.
  - BEQ, zero=0 -> pc=0x3014.
  - BNE, zero=0 -> pc=0x300C.
  - Same with BR_BASE_PC4=0, BEQ zero=1 -> pc=0x3008.
- J at pc=0x3000 with imm26=0x0000C40 -> pc=0x3100. JR with reg_target=0x0040_0007 -> pc=0x0040_0004.
- Nested call/return:
  - JAL at 0x3000 (imm26=0xC40) -> pc 0x3100, ras_count 1.
  - JAL at 0x3100 (imm26=0xC80) -> pc 0x3200, ras_count 2.
  - RET -> pc 0x3104, ras_count 1.
  - RET -> pc 0x3004, ras_count 0.
- Overflow/underflow with RAS_DEPTH=4:
  - 5 JALs pushing returns A..E -> ras_count=4.
  - 4 RETs -> returns E, D, C, B in that order.
  - 5th RET with reg_target=0x3ABC -> pc=0x3ABC and ras_underflow=1 for one cycle, then 0.
- Stall and reset:
  - JAL with stall=1 -> pc and ras_count unchanged.
  - rst=1 together with stall=1 and nPCOp=JAL -> pc=0x3000, ras_count=0.
  - Wrap case: NML at pc=0xFFFF_FFFC -> pc=0x0000_0000.
